// File: rtl/alu_muldiv_if.sv
// Execute-stage ALU bus: operation request, combinational result and HI/LO status.
interface alu_muldiv_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
);
    logic             start;
    logic [4:0]       op;
    logic             sign;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Pipeline side issuing operations
    modport master (
        output start, op, sign, in1, in2, shamt,
        input  out, zero, busy, done, hi, lo
    );

    // ALU side
    modport slave (
        input  start, op, sign, in1, in2, shamt,
        output out, zero, busy, done, hi, lo
    );
endinterface

// File: rtl/alu_muldiv.sv
// Execute-stage ALU with single-cycle ops plus an iterative radix-2
// multiply/divide unit writing the HI/LO register pair.
module alu_muldiv #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    alu_muldiv_if.slave   bus
);
    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SLT  = 5'b00111;
    localparam logic [4:0] OP_NOR  = 5'b01100;
    localparam logic [4:0] OP_XOR  = 5'b01101;
    localparam logic [4:0] OP_SLL  = 5'b10000;
    localparam logic [4:0] OP_MTHI = 5'b10110;
    localparam logic [4:0] OP_MTLO = 5'b10111;
    localparam logic [4:0] OP_SRL  = 5'b11000;
    localparam logic [4:0] OP_SRA  = 5'b11001;
    localparam logic [4:0] OP_LUI  = 5'b11010;
    localparam logic [4:0] OP_MULT = 5'b11100;
    localparam logic [4:0] OP_DIV  = 5'b11101;
    localparam logic [4:0] OP_MFHI = 5'b11110;
    localparam logic [4:0] OP_MFLO = 5'b11111;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state;
    logic [SHW-1:0]     cnt;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    // Iteration datapath: acc_hi is the partial product / partial remainder,
    // acc_lo the multiplier / dividend shifting into the quotient.
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic               div_zero;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   dvd_orig;
    logic [WIDTH:0]     acc_hi;
    logic [WIDTH-1:0]   acc_lo;

    logic               s1;
    logic               s2;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    logic               slt_bit;
    logic [WIDTH-1:0]   out_c;

    // Operand magnitudes; signs are remembered separately for the final fix-up
    assign s1   = bus.sign & bus.in1[WIDTH-1];
    assign s2   = bus.sign & bus.in2[WIDTH-1];
    assign mag1 = s1 ? -bus.in1 : bus.in1;
    assign mag2 = s2 ? -bus.in2 : bus.in2;

    // One shift-add (MULT) or restoring-subtract (DIV) step
    always_comb begin
        add_sum = acc_hi + (acc_lo[0] ? {1'b0, opa} : {(WIDTH+1){1'b0}});
        shifted = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
        trial   = shifted - {1'b0, opa};
        step_hi = acc_hi;
        step_lo = acc_lo;
        if (is_div) begin
            if (!trial[WIDTH]) begin
                step_hi = trial;
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = shifted;
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = {1'b0, add_sum[WIDTH:1]};
            step_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign fix-up and special cases applied to the last step's output
    always_comb begin
        prod     = {step_hi[WIDTH-1:0], step_lo};
        prod_fix = neg_res ? -prod : prod;
        quo      = step_lo;
        rem      = step_hi[WIDTH-1:0];
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                res_lo = '1;
                res_hi = dvd_orig;
            end else begin
                res_lo = neg_res ? -quo : quo;
                res_hi = neg_rem ? -rem : rem;
            end
        end
    end

    // Control FSM, HI/LO registers and iteration state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            opa      <= '0;
            dvd_orig <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_DIV: begin
                                state    <= RUN;
                                busy_r   <= 1'b1;
                                cnt      <= SHW'(WIDTH - 1);
                                is_div   <= (bus.op == OP_DIV);
                                neg_res  <= s1 ^ s2;
                                neg_rem  <= s1;
                                div_zero <= (bus.in2 == '0);
                                dvd_orig <= bus.in1;
                                opa      <= mag2;
                                acc_hi   <= '0;
                                acc_lo   <= mag1;
                            end
                            OP_MTHI: hi_r <= bus.in1;
                            OP_MTLO: lo_r <= bus.in1;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    if (cnt == '0) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        hi_r   <= res_hi;
                        lo_r   <= res_lo;
                    end else begin
                        cnt <= cnt - SHW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Single-cycle result mux
    always_comb begin
        slt_bit = bus.sign ? ($signed(bus.in1) < $signed(bus.in2)) : (bus.in1 < bus.in2);
        out_c   = '0;
        case (bus.op)
            OP_AND:  out_c = bus.in1 & bus.in2;
            OP_OR:   out_c = bus.in1 | bus.in2;
            OP_ADD:  out_c = bus.in1 + bus.in2;
            OP_SUB:  out_c = bus.in1 - bus.in2;
            OP_SLT:  out_c = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_NOR:  out_c = ~(bus.in1 | bus.in2);
            OP_XOR:  out_c = bus.in1 ^ bus.in2;
            OP_SLL:  out_c = bus.in2 << bus.shamt;
            OP_SRL:  out_c = bus.in2 >> bus.shamt;
            OP_SRA:  out_c = WIDTH'($signed(bus.in2) >>> bus.shamt);
            OP_LUI:  out_c = {bus.in2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_MFHI: out_c = hi_r;
            OP_MFLO: out_c = lo_r;
            default: out_c = '0;
        endcase
    end

    assign bus.out  = out_c;
    assign bus.zero = (out_c == '0);
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised scoreboard bench for alu_muldiv (32-bit and 16-bit instances).
module tb_alu_muldiv;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alu_muldiv_if #(.WIDTH(32)) b32 ();
    alu_muldiv_if #(.WIDTH(16)) b16 ();

    alu_muldiv #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
    alu_muldiv #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(b16));

    typedef struct packed {
        logic [31:0] h;
        logic [31:0] l;
    } exp_t;

    exp_t        q32[$];
    exp_t        q16[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [4:0]  comb_ops [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference multiply/divide on w-bit operands using 64-bit integer arithmetic
    function automatic void md_ref(input int w, input bit is_div, input bit sgn,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] h, output logic [31:0] l);
        longint mask, sa, sb, p, q, r;
        mask = (longint'(1) << w) - 1;
        sa = longint'(a) & mask;
        sb = longint'(b) & mask;
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        if (!is_div) begin
            p = sa * sb;
            l = 32'(p & mask);
            h = 32'((p >>> w) & mask);
        end else if (sb == 0) begin
            l = 32'(mask);
            h = 32'(sa & mask);
        end else begin
            q = sa / sb;
            r = sa % sb;
            l = 32'(q & mask);
            h = 32'(r & mask);
        end
    endfunction

    // Reference single-cycle result for the 32-bit instance
    function automatic logic [31:0] alu_ref(input logic [4:0] op, input bit sgn,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] sh);
        longint x, y;
        x = sgn ? longint'($signed(a)) : longint'(a);
        y = sgn ? longint'($signed(b)) : longint'(b);
        case (op)
            5'b00000: return a & b;
            5'b00001: return a | b;
            5'b00010: return a + b;
            5'b00110: return a - b;
            5'b00111: return (x < y) ? 32'd1 : 32'd0;
            5'b01100: return ~(a | b);
            5'b01101: return a ^ b;
            5'b10000: return b << sh;
            5'b11000: return b >> sh;
            5'b11001: return 32'(longint'($signed(b)) >>> sh);
            5'b11010: return (b & 32'h0000_FFFF) * 32'h0001_0000;
            5'b11110: return m_hi;
            5'b11111: return m_lo;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_op32();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] rnd_op16();
        case ($urandom_range(0, 5))
            0:       return 32'h0000;
            1:       return 32'h8000;
            2:       return 32'hFFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom_range(0, 65535));
        endcase
    endfunction

    task automatic comb_chk(input string name, input logic [4:0] op, input bit sgn,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] sh, input logic [31:0] exp);
        @(negedge clk);
        b32.op = op; b32.sign = sgn; b32.in1 = a; b32.in2 = b; b32.shamt = sh; b32.start = 1'b0;
        #1;
        chk(name, b32.out, exp);
        chk({name, "_zero"}, 32'(b32.zero), 32'(exp == 32'd0));
    endtask

    // Issue MULT/DIV in the current cycle; return in the cycle done is expected
    task automatic run_md32(input bit d, input bit sgn, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int cyc;
        b32.op = d ? 5'b11101 : 5'b11100;
        b32.sign = sgn; b32.in1 = a; b32.in2 = b; b32.start = 1'b1;
        q32.push_back('{h: eh, l: el});
        m_hi = eh; m_lo = el;
        @(negedge clk);
        b32.start = 1'b0; b32.in1 = $urandom; b32.in2 = $urandom; b32.sign = 1'($urandom);
        #1;
        chk("md_out32", b32.out, 32'd0);
        cyc = 0;
        while (b32.busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        chk("busy_cycles32", 32'(cyc), 32'd32);
        chk("done32", 32'(b32.done), 32'd1);
    endtask

    task automatic run_md16(input bit d, input bit sgn, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int cyc;
        b16.op = d ? 5'b11101 : 5'b11100;
        b16.sign = sgn; b16.in1 = a[15:0]; b16.in2 = b[15:0]; b16.start = 1'b1;
        q16.push_back('{h: eh, l: el});
        @(negedge clk);
        b16.start = 1'b0; b16.in1 = 16'($urandom); b16.in2 = 16'($urandom);
        #1;
        cyc = 0;
        while (b16.busy === 1'b1 && cyc < 30) begin
            cyc++;
            @(negedge clk);
        end
        chk("busy_cycles16", 32'(cyc), 32'd16);
        chk("done16", 32'(b16.done), 32'd1);
    endtask

    // Scoreboard monitors: every done pulse must match the oldest pending result
    always @(negedge clk) begin
        if (b32.done === 1'b1) begin
            chk("pending32", 32'(q32.size() != 0), 32'd1);
            if (q32.size() != 0) begin
                exp_t e;
                e = q32.pop_front();
                chk("hi32", b32.hi, e.h);
                chk("lo32", b32.lo, e.l);
            end
        end
        if (b16.done === 1'b1) begin
            chk("pending16", 32'(q16.size() != 0), 32'd1);
            if (q16.size() != 0) begin
                exp_t e;
                e = q16.pop_front();
                chk("hi16", 32'(b16.hi), e.h);
                chk("lo16", 32'(b16.lo), e.l);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, eh, el;
        logic [4:0]  op, sh;
        bit          d, sgn;
        int          cyc;

        comb_ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00110, 5'b00111, 5'b01100,
                     5'b01101, 5'b10000, 5'b11000, 5'b11001, 5'b11010, 5'b11110,
                     5'b11111, 5'b00011, 5'b10110, 5'b11100};
        reset = 1'b0;
        b32.start = 1'b0; b32.op = '0; b32.sign = 1'b0; b32.in1 = '0; b32.in2 = '0; b32.shamt = '0;
        b16.start = 1'b0; b16.op = '0; b16.sign = 1'b0; b16.in1 = '0; b16.in2 = '0; b16.shamt = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(b32.busy), 32'd0);
        chk("rst_done", 32'(b32.done), 32'd0);
        chk("rst_hi", b32.hi, 32'd0);
        chk("rst_lo", b32.lo, 32'd0);
        reset = 1'b1;

        comb_chk("mfhi_rst", 5'b11110, 1'b0, 32'h0, 32'h0, 5'd0, 32'd0);
        comb_chk("slt_s", 5'b00111, 1'b1, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1);
        comb_chk("slt_u", 5'b00111, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0);
        comb_chk("sra", 5'b11001, 1'b0, 32'h0, 32'h8000_0000, 5'd4, 32'hF800_0000);
        comb_chk("lui", 5'b11010, 1'b0, 32'h0, 32'h0000_1234, 5'd0, 32'h1234_0000);
        comb_chk("add_wrap", 5'b00010, 1'b0, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'd1);
        comb_chk("undef", 5'b00100, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'd0);

        for (int i = 0; i < 60; i++) begin
            op  = comb_ops[$urandom_range(0, 15)];
            sgn = 1'($urandom);
            a   = rnd_op32();
            b   = rnd_op32();
            sh  = 5'($urandom);
            comb_chk("comb_rnd", op, sgn, a, b, sh, alu_ref(op, sgn, a, b, sh));
        end

        // Directed MULT/DIV, issued back to back
        @(negedge clk);
        run_md32(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_md32(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_md32(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md32(1'b1, 1'b0, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        run_md32(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_md32(1'b1, 1'b1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

        // HI/LO writes, then starts and a read during RUN
        b32.op = 5'b10110; b32.in1 = 32'h1234_5678; b32.start = 1'b1;
        @(negedge clk);
        chk("mthi", b32.hi, 32'h1234_5678);
        b32.op = 5'b10111; b32.in1 = 32'd5;
        @(negedge clk);
        chk("mtlo", b32.lo, 32'd5);
        b32.start = 1'b0;
        #1;
        chk("mtlo_out", b32.out, 32'd0);
        @(negedge clk);
        b32.op = 5'b11100; b32.sign = 1'b1; b32.in1 = 32'hFFFF_FFFD; b32.in2 = 32'd5; b32.start = 1'b1;
        q32.push_back('{h: 32'hFFFF_FFFF, l: 32'hFFFF_FFF1});
        @(negedge clk);
        b32.start = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        b32.op = 5'b11101; b32.sign = 1'b0; b32.in1 = 32'd100; b32.in2 = 32'd7; b32.start = 1'b1;
        @(negedge clk);
        b32.op = 5'b10110; b32.in1 = 32'hDEAD; b32.start = 1'b1;
        @(negedge clk);
        b32.start = 1'b0; b32.op = 5'b11111;
        #1;
        chk("mflo_run", b32.out, 32'd5);
        chk("busy_run", 32'(b32.busy), 32'd1);
        chk("hi_run", b32.hi, 32'h1234_5678);
        cyc = 7;
        while (b32.busy === 1'b1 && cyc < 60) begin
            cyc++;
            @(negedge clk);
        end
        chk("coll_cycle", 32'(cyc), 32'd33);
        chk("coll_done", 32'(b32.done), 32'd1);
        m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFF1;
        repeat (40) @(negedge clk);

        // Reset in the middle of a MULT
        b32.op = 5'b11100; b32.sign = 1'b0; b32.in1 = 32'd7; b32.in2 = 32'd9; b32.start = 1'b1;
        @(negedge clk);
        b32.start = 1'b0;
        repeat (8) @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(b32.busy), 32'd0);
        chk("abort_done", 32'(b32.done), 32'd0);
        chk("abort_hi", b32.hi, 32'd0);
        chk("abort_lo", b32.lo, 32'd0);
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        repeat (40) @(negedge clk);
        comb_chk("mflo_abort", 5'b11111, 1'b0, 32'h0, 32'h0, 5'd0, 32'd0);
        @(negedge clk);
        run_md32(1'b0, 1'b0, 32'd12345, 32'd6789, 32'd0, 32'd83810205);

        // Random MULT/DIV against the reference model
        for (int i = 0; i < 30; i++) begin
            d   = 1'($urandom);
            sgn = 1'($urandom);
            a   = rnd_op32();
            b   = rnd_op32();
            md_ref(32, d, sgn, a, b, eh, el);
            run_md32(d, sgn, a, b, eh, el);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        comb_chk("mfhi_end", 5'b11110, 1'b0, 32'h0, 32'h0, 5'd0, m_hi);
        comb_chk("mflo_end", 5'b11111, 1'b0, 32'h0, 32'h0, 5'd0, m_lo);

        // 16-bit instance
        @(negedge clk);
        run_md16(1'b0, 1'b0, 32'h7FFF, 32'h7FFF, 32'h3FFF, 32'h0001);
        for (int i = 0; i < 12; i++) begin
            d   = 1'($urandom);
            sgn = 1'($urandom);
            a   = rnd_op16();
            b   = rnd_op16();
            md_ref(16, d, sgn, a, b, eh, el);
            run_md16(d, sgn, a, b, eh, el);
        end

        repeat (5) @(negedge clk);
        chk("queue_empty32", 32'(q32.size()), 32'd0);
        chk("queue_empty16", 32'(q16.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised successor of the execute-stage ALU. It keeps the same single-cycle operation set and 5-bit operation encoding, generalised to a WIDTH-bit datapath. It adds an iterative multiply/divide unit with HI/LO result registers, a start/busy/done handshake and HI/LO read/write operations. It sits in the EX stage; the hazard unit stalls the pipeline while `busy` is high.

## Interface
- WIDTH, 32, datapath width; must be even and ≥ 8.
- SHW, $clog2(WIDTH), shift-amount width.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  launch a multi-cycle op (MULT/DIV) or a HI/LO write (MTHI/MTLO); sampled on the rising edge.
- op  in  5  operation code.
- sign  in  1  1 = signed (SLT, MULT, DIV), 0 = unsigned.
- in1, in2  in  WIDTH  operands; in1 is the dividend/rs, in2 is the divisor/rt.
- shamt  in  SHW  shift amount.
- out  out  WIDTH  combinational result.
- zero  out  1  combinational, high when out == 0.
- busy  out  1  registered, high while a MULT/DIV iterates.
- done  out  1  registered, one-cycle pulse when HI/LO take a MULT/DIV result.
- hi, lo  out  WIDTH  registered HI/LO contents.

## Operation
- Combinational ops (out is a function of the inputs only; start is ignored):
  - 00000 AND, 00001 OR, 00010 ADD, 00110 SUB (wrap modulo 2^WIDTH, no overflow flag).
  - 00111 SLT: out = {0…, in1<in2}; a true two's-complement compare when sign=1, unsigned when sign=0.
  - 01100 NOR, 01101 XOR.
  - 10000 SLL in2<<shamt, 11000 SRL, 11001 SRA (fills with in2 sign bit).
  - 11010 LUI: {in2[WIDTH/2-1:0], WIDTH/2 zeros}.
  - 11110 MFHI: out = hi. 11111 MFLO: out = lo.
  - Undefined codes: out = 0.
- Register ops (take effect only with start=1, busy=0):
  - 10110 MTHI: hi <= in1.
  - 10111 MTLO: lo <= in1.
  - No busy, no done.
  - For these ops out = 0.
- Multi-cycle ops (with start=1, busy=0): operands and sign are latched, then the op iterates.
  - 11100 MULT: {hi,lo} = full 2·WIDTH-bit product. Signed when sign=1 (operands sign-extended), unsigned otherwise.
  - 11101 DIV: lo = quotient, hi = remainder. Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Divide by zero, either mode: lo = all ones, hi = in1.
  - Signed overflow (MIN / -1): lo = MIN, hi = 0.
  - Radix-2 iteration: one partial-product add or restoring-subtract step per cycle, WIDTH steps.
  - Sign fix-up is folded into the final step, so there are no extra cycles.
  - out = 0 while MULT/DIV is the op.
- State machine: IDLE -> RUN (counter WIDTH-1 down to 0) -> IDLE.
  - IDLE -> RUN on start with MULT/DIV.
  - RUN -> IDLE after the step with counter = 0; that step writes hi/lo and sets done.
- start while busy: ignored entirely, including MTHI/MTLO; operands are not re-latched.
- hi/lo keep their old values throughout RUN. MFHI/MFLO during RUN return the old values; the pipeline must stall on busy.
- Input changes during RUN have no effect on the result.

## Timing
- Reset values (reset low at an edge): busy=0, done=0, hi=0, lo=0, state IDLE, counter 0.
- Reset mid-RUN aborts the op: no done pulse, and hi/lo = 0 after that edge.
- out/zero are purely combinational and have no reset value. After reset, MFHI/MFLO give 0.
- Latency for start sampled at edge of cycle t:
  - busy is high in cycles t+1 … t+WIDTH (exactly WIDTH cycles).
  - hi/lo take the result at the edge ending cycle t+WIDTH.
  - done=1 and the new hi/lo are visible in cycle t+WIDTH+1; busy=0 in that cycle.
- Back-to-back: a new start is accepted in cycle t+WIDTH+1 (same cycle as done). The next result follows WIDTH+1 cycles later.
- MTHI/MTLO: visible on hi/lo in the cycle after the start edge.

## Test plan
- Combinational ops, WIDTH=32:
  - SLT in1=0xFFFFFFFF, in2=1, sign=1 -> out=1; same inputs with sign=0 -> out=0 and zero=1.
  - SRA in2=0x80000000, shamt=4 -> 0xF8000000.
  - LUI in2=0x1234 -> 0x12340000.
- MULT, start at cycle t:
  - sign=1, in1=-3, in2=5 -> busy in t+1…t+32; done at t+33; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - sign=0, 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV:
  - signed -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - unsigned 7/0 -> lo=0xFFFFFFFF, hi=7.
  - signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Collision and read during RUN:
  - MTLO with lo=5, then MULT start; second start (DIV) at t+5 -> ignored; result is the MULT only.
  - MFLO during RUN -> out=5.
- Reset mid-op: reset low at t+10 -> busy=0 at t+11, hi=lo=0, no done pulse ever.
  - New start right after reset completes normally.
- WIDTH=16 instance: MULT unsigned 0x7FFF×0x7FFF -> done after 17 cycles; hi=0x3FFF, lo=0x0001.
